pattern_serializer: RTL and testbench



---
 rtl/pattern_serializer.sv | 143 ++++++++++++++
 tb/tb_pattern_serializer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pattern_serializer.sv
// Bit-serial pattern transmitter: accepts a parallel word over valid/ready and
// shifts it out MSB first, optionally repeating it with an idle gap after each pass.
module pattern_serializer #(
    parameter int MAX_LEN = 16,
    parameter int GAP_W   = 4,
    parameter int REP_W   = 4,
    localparam int LEN_W  = $clog2(MAX_LEN) + 1,
    localparam int IDX_W  = $clog2(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MAX_LEN-1:0] pat_data,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic [REP_W-1:0]   pat_repeat,
    input  logic [GAP_W-1:0]   pat_gap,
    input  logic               pat_valid,
    output logic               pat_ready,
    output logic               dout,
    output logic               dout_valid,
    output logic               done,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t             state_q, state_n;
    logic [MAX_LEN-1:0] data_q, data_n;
    logic [LEN_W-1:0]   len_q, len_n;
    logic [GAP_W-1:0]   gap_q, gap_n;
    logic [REP_W-1:0]   pass_q, pass_n;
    logic [LEN_W-1:0]   bit_q, bit_n;
    logic [GAP_W-1:0]   gapcnt_q, gapcnt_n;
    logic               more_q, more_n;

    logic               accept;
    logic               end_of_pass;
    logic [LEN_W-1:0]   len_eff;
    logic [IDX_W-1:0]   bit_idx;
    logic               dout_n, dout_valid_n, done_n, busy_n, ready_n;

    assign accept      = pat_valid && pat_ready && (state_q == S_IDLE);
    assign end_of_pass = (bit_q == len_q - LEN_W'(1));
    assign len_eff     = (pat_len == '0 || pat_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pat_len;

    // NOTE: every signal gets its hold value first so no path can infer a latch.
    always_comb begin
        state_n  = state_q;
        data_n   = data_q;
        len_n    = len_q;
        gap_n    = gap_q;
        pass_n   = pass_q;
        bit_n    = bit_q;
        gapcnt_n = gapcnt_q;
        more_n   = more_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_n  = S_SHIFT;
                    data_n   = pat_data;
                    len_n    = len_eff;
                    gap_n    = pat_gap;
                    pass_n   = pat_repeat;
                    bit_n    = '0;
                    gapcnt_n = '0;
                    more_n   = 1'b0;
                end
            end
            S_SHIFT: begin
                if (end_of_pass) begin
                    // more_q remembers across the gap whether another pass follows
                    more_n = (pass_q != '0);
                    if (pass_q != '0)
                        pass_n = pass_q - REP_W'(1);
                    bit_n = '0;
                    if (gap_q != '0) begin
                        state_n  = S_GAP;
                        gapcnt_n = gap_q - GAP_W'(1);
                    end else if (pass_q == '0) begin
                        state_n = S_IDLE;
                    end
                end else begin
                    bit_n = bit_q + LEN_W'(1);
                end
            end
            S_GAP: begin
                if (gapcnt_q == '0) begin
                    bit_n   = '0;
                    state_n = more_q ? S_SHIFT : S_IDLE;
                end else begin
                    gapcnt_n = gapcnt_q - GAP_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the next-cycle values.
    assign bit_idx      = IDX_W'(len_n - LEN_W'(1) - bit_n);
    assign dout_valid_n = (state_n == S_SHIFT);
    assign dout_n       = dout_valid_n & data_n[bit_idx];
    assign done_n       = dout_valid_n && (bit_n == len_n - LEN_W'(1)) && (pass_n == '0);
    assign busy_n       = (state_n != S_IDLE);
    assign ready_n      = (state_n == S_IDLE);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            len_q      <= '0;
            gap_q      <= '0;
            pass_q     <= '0;
            bit_q      <= '0;
            gapcnt_q   <= '0;
            more_q     <= 1'b0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            pat_ready  <= 1'b1;
        end else begin
            state_q    <= state_n;
            data_q     <= data_n;
            len_q      <= len_n;
            gap_q      <= gap_n;
            pass_q     <= pass_n;
            bit_q      <= bit_n;
            gapcnt_q   <= gapcnt_n;
            more_q     <= more_n;
            dout       <= dout_n;
            dout_valid <= dout_valid_n;
            done       <= done_n;
            busy       <= busy_n;
            pat_ready  <= ready_n;
        end
    end

endmodule

// File: tb/tb_pattern_serializer.sv
// Self-checking bench for pattern_serializer: directed cases plus random requests,
// compared cycle by cycle against a stream built from the pattern/repeat/gap rules.
module tb_pattern_serializer;

    localparam int MAX_LEN = 16;
    localparam int GAP_W   = 4;
    localparam int REP_W   = 4;
    localparam int LEN_W   = $clog2(MAX_LEN) + 1;

    logic               clk;
    logic               rst;
    logic [MAX_LEN-1:0] pat_data;
    logic [LEN_W-1:0]   pat_len;
    logic [REP_W-1:0]   pat_repeat;
    logic [GAP_W-1:0]   pat_gap;
    logic               pat_valid;
    logic               pat_ready;
    logic               dout;
    logic               dout_valid;
    logic               done;
    logic               busy;

    int checks = 0;
    int errors = 0;
    bit stream_q[$];

    // observation vector: {busy, pat_ready, dout_valid, dout, done}
    localparam logic [4:0] IDLE_OBS = 5'b01000;

    pattern_serializer #(
        .MAX_LEN(MAX_LEN),
        .GAP_W  (GAP_W),
        .REP_W  (REP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pat_data  (pat_data),
        .pat_len   (pat_len),
        .pat_repeat(pat_repeat),
        .pat_gap   (pat_gap),
        .pat_valid (pat_valid),
        .pat_ready (pat_ready),
        .dout      (dout),
        .dout_valid(dout_valid),
        .done      (done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] obs();
        return {busy, pat_ready, dout_valid, dout, done};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends one request and checks every cycle against the expected stream.
    task automatic run_req(input string tag, input logic [15:0] data, input logic [4:0] len,
                           input logic [3:0] rep, input logic [3:0] gap);
        logic [4:0] exp_q[$];
        int eff;
        int w;
        eff = (len == 0 || len > MAX_LEN) ? MAX_LEN : int'(len);
        for (int p = 0; p <= int'(rep); p++) begin
            for (int b = eff - 1; b >= 0; b--)
                exp_q.push_back({1'b1, 1'b0, 1'b1, data[b], (p == int'(rep) && b == 0)});
            for (int g = 0; g < int'(gap); g++)
                exp_q.push_back(5'b10000);
        end

        w = 0;
        while (!pat_ready && w < 1000) begin
            step();
            w++;
        end
        check({tag, "_ready_in"}, 32'(pat_ready), 32'd1);

        pat_data   = data;
        pat_len    = len;
        pat_repeat = rep;
        pat_gap    = gap;
        pat_valid  = 1'b1;
        step();
        // scramble inputs after acceptance; latched fields must not follow
        pat_data   = MAX_LEN'($urandom);
        pat_len    = LEN_W'($urandom);
        pat_repeat = REP_W'($urandom);
        pat_gap    = GAP_W'($urandom);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_c%0d", tag, i), 32'(obs()), 32'(exp_q[i]));
            if (dout_valid)
                stream_q.push_back(dout);
            pat_valid = (i < exp_q.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
        end
        check({tag, "_end"}, 32'(obs()), 32'(IDLE_OBS));
    endtask

    initial begin
        int cnt;
        rst        = 1'b1;
        pat_valid  = 1'b0;
        pat_data   = '0;
        pat_len    = '0;
        pat_repeat = '0;
        pat_gap    = '0;
        step();
        step();
        check("in_reset", 32'(obs()), 32'(IDLE_OBS));
        @(negedge clk);
        rst = 1'b0;
        step();
        check("after_reset", 32'(obs()), 32'(IDLE_OBS));

        run_req("single",  16'h000B, 5'd4, 4'd0, 4'd0);
        run_req("rep_gap", 16'h0005, 5'd3, 4'd2, 4'd2);
        run_req("b2b",     16'h000D, 5'd4, 4'd1, 4'd0);
        run_req("clamp0",  16'hA5C3, 5'd0, 4'd0, 4'd0);
        run_req("clamp31", 16'hA5C3, 5'd31, 4'd0, 4'd0);
        run_req("len1",    16'h0001, 5'd1, 4'd2, 4'd1);

        // reset during the third bit of a 16-bit pass
        pat_data  = 16'hA5C3;
        pat_len   = 5'd16;
        pat_repeat = 4'd0;
        pat_gap   = 4'd0;
        pat_valid = 1'b1;
        step();
        pat_valid = 1'b0;
        step();
        step();
        check("pre_rst_bit3", 32'(obs()), 32'(5'b10110));
        rst = 1'b1;
        #1;
        check("rst_async", 32'(obs()), 32'(IDLE_OBS));
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("rst_hold%0d", i), 32'(obs()), 32'(IDLE_OBS));
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        check("rst_release", 32'(obs()), 32'(IDLE_OBS));
        run_req("post_rst", 16'h8001, 5'd16, 4'd0, 4'd0);

        // stream 1011 1011 1011 into a 1011 overlapping detector model
        stream_q.delete();
        run_req("det", 16'h0BBB, 5'd12, 4'd0, 4'd0);
        cnt = 0;
        for (int i = 3; i < stream_q.size(); i++)
            if ({stream_q[i-3], stream_q[i-2], stream_q[i-1], stream_q[i]} == 4'b1011)
                cnt++;
        check("det_count", 32'(cnt), 32'd3);

        for (int k = 0; k < 20; k++)
            run_req($sformatf("rand%0d", k), 16'($urandom), 5'($urandom_range(0, 31)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
